// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the block-memory arbiter: FSM states,
// grant encodings and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_RD    = 3'd1,
    D_RD    = 3'd2,
    D_WR    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IRD  = 2'd1;
  localparam logic [1:0] GNT_DRD  = 2'd2;
  localparam logic [1:0] GNT_DWR  = 2'd3;

  // Round-robin pointer encoding: which read port was served last.
  localparam logic RR_LAST_I = 1'b0;
  localparam logic RR_LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin picker; bit 0 is the I-cache read port,
// bit 1 the D-cache read port.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_rd_q;
  logic last_rd_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_rd_q == RR_LAST_D) ? 2'b01 : 2'b10;
    end
  end

  // The pointer only moves when a read is actually granted.
  always_comb begin
    last_rd_d = last_rd_q;
    if (advance && (gnt != 2'b00)) begin
      last_rd_d = gnt[1] ? RR_LAST_D : RR_LAST_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd_q <= RR_LAST_D;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single block memory between I-cache refills, D-cache
// refills and D-cache writebacks; writebacks first, reads round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              i_r_valid,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic              i_r_ready,
  output logic [DATA_W-1:0] i_r_data,

  input  logic              d_r_valid,
  input  logic [ADDR_W-1:0] d_r_addr,
  output logic              d_r_ready,
  output logic [DATA_W-1:0] d_r_data,

  input  logic              d_w_valid,
  input  logic [ADDR_W-1:0] d_w_addr,
  input  logic [DATA_W-1:0] d_w_data,
  output logic              d_w_ready,

  output logic              m_r_valid,
  output logic              m_w_valid,
  output logic [ADDR_W-1:0] m_r_addr,
  output logic [ADDR_W-1:0] m_w_addr,
  output logic [DATA_W-1:0] m_w_data,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic              m_r_ready,
  input  logic              m_w_ready,

  output logic [1:0]        grant,
  output logic              busy
);

  state_e            state_q;
  logic              m_r_valid_q;
  logic              m_w_valid_q;
  logic [ADDR_W-1:0] m_r_addr_q;
  logic [ADDR_W-1:0] m_w_addr_q;
  logic [DATA_W-1:0] m_w_data_q;
  logic [1:0]        grant_q;
  logic              busy_q;

  logic [1:0]        rr_gnt;
  logic              rr_advance;

  // A pending writeback pre-empts the read pick, so the pointer must not move then.
  assign rr_advance = (state_q == IDLE) && !d_w_valid;

  mem_arb_rr u_rr (
    .clk     (clk),
    .rst     (rstn),
    .req     ({d_r_valid, i_r_valid}),
    .advance (rr_advance),
    .gnt     (rr_gnt)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= IDLE;
      m_r_valid_q <= 1'b0;
      m_w_valid_q <= 1'b0;
      m_r_addr_q  <= '0;
      m_w_addr_q  <= '0;
      m_w_data_q  <= '0;
      grant_q     <= GNT_NONE;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_w_valid) begin
            state_q     <= D_WR;
            m_w_valid_q <= 1'b1;
            m_w_addr_q  <= d_w_addr;
            m_w_data_q  <= d_w_data;
            grant_q     <= GNT_DWR;
            busy_q      <= 1'b1;
          end else if (rr_gnt[0]) begin
            state_q     <= I_RD;
            m_r_valid_q <= 1'b1;
            m_r_addr_q  <= i_r_addr;
            grant_q     <= GNT_IRD;
            busy_q      <= 1'b1;
          end else if (rr_gnt[1]) begin
            state_q     <= D_RD;
            m_r_valid_q <= 1'b1;
            m_r_addr_q  <= d_r_addr;
            grant_q     <= GNT_DRD;
            busy_q      <= 1'b1;
          end
        end
        I_RD, D_RD: begin
          if (m_r_ready) begin
            state_q     <= RELEASE;
            m_r_valid_q <= 1'b0;
            grant_q     <= GNT_NONE;
            busy_q      <= 1'b0;
          end
        end
        D_WR: begin
          if (m_w_ready) begin
            state_q     <= RELEASE;
            m_w_valid_q <= 1'b0;
            grant_q     <= GNT_NONE;
            busy_q      <= 1'b0;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          m_r_valid_q <= 1'b0;
          m_w_valid_q <= 1'b0;
          grant_q     <= GNT_NONE;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Memory completions reach only the requester that owns the grant.
  assign i_r_ready = (state_q == I_RD) && m_r_ready;
  assign d_r_ready = (state_q == D_RD) && m_r_ready;
  assign d_w_ready = (state_q == D_WR) && m_w_ready;

  assign i_r_data  = m_r_data;
  assign d_r_data  = m_r_data;

  assign m_r_valid = m_r_valid_q;
  assign m_w_valid = m_w_valid_q;
  assign m_r_addr  = m_r_addr_q;
  assign m_w_addr  = m_w_addr_q;
  assign m_w_data  = m_w_data_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for reset abort and writeback pre-emption.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 128;

  localparam logic [DW-1:0] RD_A = 128'hDEADBEEF_0BADF00D_CAFEF00D_12345678;
  localparam logic [DW-1:0] RD_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [DW-1:0] WB1  = {4{32'h11111111}};
  localparam logic [DW-1:0] WB2  = {4{32'hA5A5_5A5A}};
  localparam logic [DW-1:0] WB3  = {4{32'h3C3C_C3C3}};

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_r_valid, d_r_valid, d_w_valid;
  logic [AW-1:0] i_r_addr, d_r_addr, d_w_addr;
  logic [DW-1:0] d_w_data;
  logic          i_r_ready, d_r_ready, d_w_ready;
  logic [DW-1:0] i_r_data, d_r_data;
  logic          m_r_valid, m_w_valid;
  logic [AW-1:0] m_r_addr, m_w_addr;
  logic [DW-1:0] m_w_data, m_r_data;
  logic          m_r_ready, m_w_ready;
  logic [1:0]    grant;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_r_valid (i_r_valid),
    .i_r_addr  (i_r_addr),
    .i_r_ready (i_r_ready),
    .i_r_data  (i_r_data),
    .d_r_valid (d_r_valid),
    .d_r_addr  (d_r_addr),
    .d_r_ready (d_r_ready),
    .d_r_data  (d_r_data),
    .d_w_valid (d_w_valid),
    .d_w_addr  (d_w_addr),
    .d_w_data  (d_w_data),
    .d_w_ready (d_w_ready),
    .m_r_valid (m_r_valid),
    .m_w_valid (m_w_valid),
    .m_r_addr  (m_r_addr),
    .m_w_addr  (m_w_addr),
    .m_w_data  (m_w_data),
    .m_r_data  (m_r_data),
    .m_r_ready (m_r_ready),
    .m_w_ready (m_w_ready),
    .grant     (grant),
    .busy      (busy)
  );

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic          dv;
    logic [AW-1:0] da;
    logic          wv;
    logic [AW-1:0] wa;
    logic          mrr;
    logic          mwr;
    logic [1:0]    e_gnt;
    logic          e_busy;
    logic          e_mrv;
    logic          e_mwv;
    logic [AW-1:0] e_ra;
    logic [AW-1:0] e_wa;
    logic          e_ir;
    logic          e_dr;
    logic          e_dw;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic iv, input logic [AW-1:0] ia, input logic dv, input logic [AW-1:0] da,
    input logic wv, input logic [AW-1:0] wa, input logic mrr, input logic mwr,
    input logic [1:0] eg, input logic eb, input logic emrv, input logic emwv,
    input logic [AW-1:0] era, input logic [AW-1:0] ewa,
    input logic eir, input logic edr, input logic edw);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.wv = wv; v.wa = wa;
    v.mrr = mrr; v.mwr = mwr; v.e_gnt = eg; v.e_busy = eb; v.e_mrv = emrv;
    v.e_mwv = emwv; v.e_ra = era; v.e_wa = ewa; v.e_ir = eir; v.e_dr = edr; v.e_dw = edw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_r_valid = 1'b0; i_r_addr = '0;
    d_r_valid = 1'b0; d_r_addr = '0;
    d_w_valid = 1'b0; d_w_addr = '0; d_w_data = '0;
    m_r_ready = 1'b0; m_w_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Tie between both reads, repeated: I, D, I, D.
    vq.push_back(mk(1,8'h10,1,8'h20,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h10,1,8'h20,0,8'h00,1,0, 1,1,1,0,8'h10,8'h00,1,0,0));
    vq.push_back(mk(0,8'h10,1,8'h20,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h11,1,8'h20,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h11,1,8'h20,0,8'h00,1,0, 2,1,1,0,8'h20,8'h00,0,1,0));
    vq.push_back(mk(1,8'h11,0,8'h20,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h11,1,8'h21,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h11,1,8'h21,0,8'h00,1,0, 1,1,1,0,8'h11,8'h00,1,0,0));
    vq.push_back(mk(0,8'h11,1,8'h21,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h12,1,8'h21,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h12,1,8'h21,0,8'h00,1,0, 2,1,1,0,8'h21,8'h00,0,1,0));
    vq.push_back(mk(0,8'h12,0,8'h21,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    // Single I refill at 0x3A, memory answers in the third granted cycle.
    vq.push_back(mk(1,8'h3A,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h3A,0,8'h00,0,8'h00,0,0, 1,1,1,0,8'h3A,8'h00,0,0,0));
    vq.push_back(mk(1,8'h3A,0,8'h00,0,8'h00,0,0, 1,1,1,0,8'h3A,8'h00,0,0,0));
    vq.push_back(mk(1,8'h3A,0,8'h00,0,8'h00,1,0, 1,1,1,0,8'h3A,8'h00,1,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    // Writeback and refill from the D-cache together: writeback first.
    vq.push_back(mk(0,8'h00,1,8'h05,1,8'hE5,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,1,8'h05,1,8'hE5,0,0, 3,1,0,1,8'h00,8'hE5,0,0,0));
    vq.push_back(mk(0,8'h00,1,8'h05,1,8'hE5,0,1, 3,1,0,1,8'h00,8'hE5,0,0,1));
    vq.push_back(mk(0,8'h00,1,8'h05,0,8'hE5,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,1,8'h05,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,1,8'h05,0,8'h00,1,0, 2,1,1,0,8'h05,8'h00,0,1,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    // Stray write-ready during I_RD, then readys in RELEASE and IDLE.
    vq.push_back(mk(1,8'h2C,0,8'h00,0,8'h00,0,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(1,8'h2C,0,8'h00,0,8'h00,0,1, 1,1,1,0,8'h2C,8'h00,0,0,0));
    vq.push_back(mk(1,8'h2C,0,8'h00,0,8'h00,0,0, 1,1,1,0,8'h2C,8'h00,0,0,0));
    vq.push_back(mk(1,8'h2C,0,8'h00,0,8'h00,1,0, 1,1,1,0,8'h2C,8'h00,1,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,1,0, 0,0,0,0,8'h00,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0,8'h00,1,1, 0,0,0,0,8'h00,8'h00,0,0,0));

    // Reset state, with memory readys driven to show they are not forwarded.
    rstn = 1'b1;
    idle_inputs();
    m_r_data = RD_A;
    m_r_ready = 1'b1;
    m_w_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst grant", grant, GNT0());
    chk("rst busy", busy, 0);
    chk("rst m_r_valid", m_r_valid, 0);
    chk("rst m_w_valid", m_w_valid, 0);
    chk("rst m_r_addr", m_r_addr, 0);
    chk("rst i_r_ready", i_r_ready, 0);
    chk("rst d_w_ready", d_w_ready, 0);
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      i_r_valid = v.iv; i_r_addr = v.ia;
      d_r_valid = v.dv; d_r_addr = v.da;
      d_w_valid = v.wv; d_w_addr = v.wa; d_w_data = WB1;
      m_r_ready = v.mrr; m_w_ready = v.mwr;
      #1;
      chk($sformatf("v%0d grant", i), grant, v.e_gnt);
      chk($sformatf("v%0d busy", i), busy, v.e_busy);
      chk($sformatf("v%0d m_r_valid", i), m_r_valid, v.e_mrv);
      chk($sformatf("v%0d m_w_valid", i), m_w_valid, v.e_mwv);
      chk($sformatf("v%0d i_r_ready", i), i_r_ready, v.e_ir);
      chk($sformatf("v%0d d_r_ready", i), d_r_ready, v.e_dr);
      chk($sformatf("v%0d d_w_ready", i), d_w_ready, v.e_dw);
      if (v.e_mrv) chk($sformatf("v%0d m_r_addr", i), m_r_addr, v.e_ra);
      if (v.e_mwv) begin
        chk($sformatf("v%0d m_w_addr", i), m_w_addr, v.e_wa);
        chk($sformatf("v%0d m_w_data", i), m_w_data, WB1);
      end
      if (v.e_ir) chk($sformatf("v%0d i_r_data", i), i_r_data, RD_A);
      if (v.e_dr) chk($sformatf("v%0d d_r_data", i), d_r_data, RD_A);
    end

    // Reset in the middle of a writeback; the pointer was last left at I.
    @(negedge clk);
    idle_inputs();
    m_r_data = RD_B;
    d_w_valid = 1'b1; d_w_addr = 8'h40; d_w_data = WB2;
    @(negedge clk); #1;
    chk("rstwb grant", grant, 2'd3);
    chk("rstwb m_w_valid", m_w_valid, 1);
    @(negedge clk);
    rstn = 1'b1;
    m_w_ready = 1'b1;
    #1;
    chk("rstwb abort m_w_valid", m_w_valid, 0);
    chk("rstwb abort grant", grant, 0);
    chk("rstwb abort busy", busy, 0);
    chk("rstwb abort d_w_ready", d_w_ready, 0);
    chk("rstwb abort m_w_addr", m_w_addr, 0);
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    i_r_valid = 1'b1; i_r_addr = 8'h12;
    d_r_valid = 1'b1; d_r_addr = 8'h34;
    #1;
    chk("postrst idle grant", grant, 0);
    @(negedge clk);
    m_r_ready = 1'b1;
    #1;
    chk("postrst tie grant", grant, 2'd1);
    chk("postrst m_r_addr", m_r_addr, 8'h12);
    chk("postrst m_r_valid", m_r_valid, 1);
    chk("postrst i_r_ready", i_r_ready, 1);
    chk("postrst i_r_data", i_r_data, RD_B);
    chk("postrst d_r_ready", d_r_ready, 0);
    @(negedge clk);
    m_r_ready = 1'b0; i_r_valid = 1'b0;
    #1;
    chk("postrst release grant", grant, 0);
    @(negedge clk); #1;
    chk("postrst idle2 grant", grant, 0);
    @(negedge clk);
    m_r_ready = 1'b1;
    #1;
    chk("postrst d grant", grant, 2'd2);
    chk("postrst d m_r_addr", m_r_addr, 8'h34);
    chk("postrst d_r_ready", d_r_ready, 1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // A new writeback overtakes a read queued during the previous writeback.
    @(negedge clk);
    d_w_valid = 1'b1; d_w_addr = 8'h70; d_w_data = WB2;
    @(negedge clk);
    i_r_valid = 1'b1; i_r_addr = 8'h33;
    #1;
    chk("pre wb1 grant", grant, 2'd3);
    chk("pre wb1 m_w_addr", m_w_addr, 8'h70);
    @(negedge clk);
    m_w_ready = 1'b1;
    #1;
    chk("pre wb1 d_w_ready", d_w_ready, 1);
    chk("pre wb1 i_r_ready", i_r_ready, 0);
    @(negedge clk);
    m_w_ready = 1'b0; d_w_valid = 1'b0;
    #1;
    chk("pre rel1 busy", busy, 0);
    @(negedge clk);
    d_w_valid = 1'b1; d_w_addr = 8'h71; d_w_data = WB3;
    #1;
    chk("pre idle grant", grant, 0);
    @(negedge clk);
    m_w_ready = 1'b1;
    #1;
    chk("pre wb2 grant", grant, 2'd3);
    chk("pre wb2 m_w_addr", m_w_addr, 8'h71);
    chk("pre wb2 m_w_data", m_w_data, WB3);
    chk("pre wb2 d_w_ready", d_w_ready, 1);
    @(negedge clk);
    m_w_ready = 1'b0; d_w_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_r_ready = 1'b1;
    #1;
    chk("pre rd grant", grant, 2'd1);
    chk("pre rd m_r_addr", m_r_addr, 8'h33);
    chk("pre rd i_r_ready", i_r_ready, 1);
    chk("pre rd i_r_data", i_r_data, RD_B);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre final grant", grant, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  function automatic logic [1:0] GNT0();
    return 2'd0;
  endfunction

endmodule
